// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single memory module between the core port (fetch / memory
// stage) and a DMA/debug port. One port is granted at a time; the winner's
// request fields are latched onto the memory interface and held until the
// memory completes. The winner sees the same busy-until-done contract the
// memory module itself presents, so requester FSMs need no change.
//
// Arbitration: the core has fixed priority. While DMA is waiting, the
// consecutive core grants are counted. Once CORE_BURST core grants have gone
// by, the DMA port wins the next grant even if the core is also requesting.
//
// Access sequence: IDLE (grant, latch) -> ACTIVE (wait for ~mem_busy)
// -> RELEASE (one idle cycle) -> IDLE. With zero-wait memory an access
// takes three cycles.
//
// Optional feature (macro MEM_ARB_LOCK_EN):
//   dma_lock is sampled when a DMA access completes. If it is set, the arbiter
//   keeps granting only DMA until a DMA access completes with dma_lock low,
//   or until the arbiter is idle with dma_req low. Without the macro, dma_lock
//   is ignored and no lock logic is built.
//
// Parameters
//   CORE_BURST  max consecutive core grants while dma_req is pending (>= 1)
//
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   core_req/write/size/addr/wdata     core request; held stable while req high
//   core_rdata, core_busy, core_fault  core response (valid on completion)
//   dma_req/write/size/addr/wdata      DMA request; held stable while req high
//   dma_rdata, dma_busy, dma_fault     DMA response (valid on completion)
//   dma_lock                           hold DMA ownership (MEM_ARB_LOCK_EN)
//   mem_enable/write/size/addr/wdata   registered memory request
//   mem_out, mem_busy                  memory read data, busy
//   mem_op/addr/access_fault           memory fault flags
//   arb_owner                          0 = core, 1 = DMA (current/last grant)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int CORE_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        core_req,
  input  logic        core_write,
  input  logic [1:0]  core_size,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_busy,
  output logic [2:0]  core_fault,

  input  logic        dma_req,
  input  logic        dma_write,
  input  logic [1:0]  dma_size,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_busy,
  output logic [2:0]  dma_fault,
  input  logic        dma_lock,

  output logic        mem_enable,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_out,
  input  logic        mem_busy,
  input  logic        mem_op_fault,
  input  logic        mem_addr_fault,
  input  logic        mem_access_fault,

  output logic        arb_owner
);

  // Counter wide enough to hold CORE_BURST itself (the saturation value).
  localparam int CNT_W = (CORE_BURST < 1) ? 1 : $clog2(CORE_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(CORE_BURST);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             owner_q;

  logic             any_req;
  logic             pick_dma;
  logic             grant;
  logic             done;
  logic             core_done;
  logic             dma_done;
  logic             lock_hold;
  logic [2:0]       fault_vec;

  logic             sel_write;
  logic [1:0]       sel_size;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;

  // -------------------------------------------------------------------------
  // Optional DMA lock
  // -------------------------------------------------------------------------
`ifdef MEM_ARB_LOCK_EN
  logic lock_q, lock_d;

  // The lock only steers grants while DMA is actually requesting; an idle
  // arbiter with dma_req low drops the lock and falls back to normal rules.
  assign lock_hold = lock_q & dma_req;

  always_comb begin
    lock_d = lock_q;
    if ((state_q == ST_IDLE) && !dma_req) begin
      lock_d = 1'b0;
    end
    if (dma_done) begin
      lock_d = dma_lock;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  logic unused_dma_lock;

  assign unused_dma_lock = dma_lock;
  assign lock_hold       = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Arbitration decision (evaluated every cycle, acted on only in IDLE)
  // -------------------------------------------------------------------------
  assign any_req  = core_req | dma_req;
  assign pick_dma = dma_req & (~core_req | (count_q == BURST_MAX) | lock_hold);

  // Winner's request fields, ready to be latched onto the memory interface.
  always_comb begin
    sel_write = core_write;
    sel_size  = core_size;
    sel_addr  = core_addr;
    sel_wdata = core_wdata;
    if (pick_dma) begin
      sel_write = dma_write;
      sel_size  = dma_size;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  // Completion is the memory's own contract: enabled and not busy.
  assign done      = (state_q == ST_ACTIVE) & mem_enable & ~mem_busy;
  assign core_done = done & ~owner_q;
  assign dma_done  = done &  owner_q;

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant   = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (done) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Starvation counter: counts core grants made while DMA waits. Any grant
  // with DMA not waiting, or a DMA grant, starts the count over.
  always_comb begin
    count_d = count_q;
    if (grant) begin
      if (pick_dma || !dma_req) begin
        count_d = '0;
      end else if (count_q != BURST_MAX) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Registered memory interface and owner
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      mem_size   <= 2'b00;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      owner_q    <= 1'b0;
    end else if (grant) begin
      mem_enable <= 1'b1;
      mem_write  <= sel_write;
      mem_size   <= sel_size;
      mem_addr   <= sel_addr;
      mem_wdata  <= sel_wdata;
      owner_q    <= pick_dma;
    end else if (done) begin
      // Fields stay as last latched; only the enable drops.
      mem_enable <= 1'b0;
    end
  end

  assign arb_owner = owner_q;

  // -------------------------------------------------------------------------
  // Port responses (combinational in the completion cycle)
  // -------------------------------------------------------------------------
  assign fault_vec = {mem_op_fault, mem_addr_fault, mem_access_fault};

  // A requesting port stays busy until its own completion cycle; the
  // non-owner therefore waits transparently while the other port is served.
  assign core_busy  = core_req & ~core_done;
  assign dma_busy   = dma_req  & ~dma_done;

  assign core_rdata = core_done ? mem_out   : 32'h0;
  assign dma_rdata  = dma_done  ? mem_out   : 32'h0;
  assign core_fault = core_done ? fault_vec : 3'b000;
  assign dma_fault  = dma_done  ? fault_vec : 3'b000;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;

  logic        core_req, core_write;
  logic [1:0]  core_size;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_busy;
  logic [2:0]  core_fault;

  logic        dma_req, dma_write, dma_lock;
  logic [1:0]  dma_size;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_busy;
  logic [2:0]  dma_fault;

  logic        mem_enable, mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_out;
  logic        mem_busy, mem_op_fault, mem_addr_fault, mem_access_fault;
  logic        arb_owner;

  // Memory model controls
  logic [3:0]  wait_cyc;
  logic [3:0]  mcnt;
  logic        f_op, f_addr, f_acc;

  int n_checks;
  int n_fail;

  mem_arbiter #(.CORE_BURST(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .core_req         (core_req),
    .core_write       (core_write),
    .core_size        (core_size),
    .core_addr        (core_addr),
    .core_wdata       (core_wdata),
    .core_rdata       (core_rdata),
    .core_busy        (core_busy),
    .core_fault       (core_fault),
    .dma_req          (dma_req),
    .dma_write        (dma_write),
    .dma_size         (dma_size),
    .dma_addr         (dma_addr),
    .dma_wdata        (dma_wdata),
    .dma_rdata        (dma_rdata),
    .dma_busy         (dma_busy),
    .dma_fault        (dma_fault),
    .dma_lock         (dma_lock),
    .mem_enable       (mem_enable),
    .mem_write        (mem_write),
    .mem_size         (mem_size),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_out          (mem_out),
    .mem_busy         (mem_busy),
    .mem_op_fault     (mem_op_fault),
    .mem_addr_fault   (mem_addr_fault),
    .mem_access_fault (mem_access_fault),
    .arb_owner        (arb_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple memory: busy for wait_cyc cycles after enable, faults only on completion.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)        mcnt <= 4'd0;
    else if (mem_enable) mcnt <= mcnt + 4'd1;
    else                 mcnt <= 4'd0;
  end
  assign mem_busy         = mem_enable && (mcnt < wait_cyc);
  assign mem_op_fault     = f_op   & mem_enable & ~mem_busy;
  assign mem_addr_fault   = f_addr & mem_enable & ~mem_busy;
  assign mem_access_fault = f_acc  & mem_enable & ~mem_busy;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (mem_enable && !mem_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    core_req = 0; core_write = 0; core_size = 0; core_addr = 0; core_wdata = 0;
    dma_req = 0; dma_write = 0; dma_size = 0; dma_addr = 0; dma_wdata = 0; dma_lock = 0;
    mem_out = 32'h0; wait_cyc = 4'd0; f_op = 0; f_addr = 0; f_acc = 0;
    #22;
    n_checks++; if (mem_enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable: got %b want 0", mem_enable); end
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b want 0", mem_write); end
    n_checks++; if (mem_size !== 2'b00) begin n_fail++; $display("FAIL rst_size: got %b want 00", mem_size); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    n_checks++; if (arb_owner !== 1'b0) begin n_fail++; $display("FAIL rst_owner: got %b want 0", arb_owner); end
    n_checks++; if (core_busy !== 1'b0 || dma_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b%b want 00", core_busy, dma_busy); end
    step();
    reset_n = 1'b1;
    step();
    n_checks++; if (mem_enable !== 1'b0) begin n_fail++; $display("FAIL rst_idle_enable: got %b want 0", mem_enable); end
  endtask

  task automatic test_core_only();
    wait_cyc = 4'd0; mem_out = 32'hDEADBEEF;
    core_req = 1; core_write = 0; core_size = 2'b10; core_addr = 32'h100;
    #1;
    n_checks++; if (core_busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_pre: got %b want 1", core_busy); end
    n_checks++; if (mem_enable !== 1'b0) begin n_fail++; $display("FAIL t1_enable_pre: got %b want 0", mem_enable); end
    step();
    n_checks++; if (mem_enable !== 1'b1) begin n_fail++; $display("FAIL t1_enable: got %b want 1", mem_enable); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL t1_addr: got %h want 100", mem_addr); end
    n_checks++; if (mem_size !== 2'b10 || mem_write !== 1'b0) begin n_fail++; $display("FAIL t1_fields: got %b/%b want 10/0", mem_size, mem_write); end
    n_checks++; if (arb_owner !== 1'b0) begin n_fail++; $display("FAIL t1_owner: got %b want 0", arb_owner); end
    n_checks++; if (core_busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_done: got %b want 0", core_busy); end
    n_checks++; if (core_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_rdata: got %h want deadbeef", core_rdata); end
    n_checks++; if (core_fault !== 3'b000) begin n_fail++; $display("FAIL t1_fault: got %b want 000", core_fault); end
    core_req = 0;
    step();
    n_checks++; if (mem_enable !== 1'b0) begin n_fail++; $display("FAIL t1_release: got %b want 0", mem_enable); end
    step();
  endtask

  task automatic test_simultaneous();
    bit ok;
    wait_cyc = 4'd0; mem_out = 32'h12345678;
    core_req = 1; core_write = 0; core_addr = 32'h200;
    dma_req = 1; dma_write = 0; dma_size = 2'b10; dma_addr = 32'h300;
    wait_done(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t2_core_timeout: got no completion want completion"); end
    n_checks++; if (arb_owner !== 1'b0) begin n_fail++; $display("FAIL t2_first_owner: got %b want 0", arb_owner); end
    n_checks++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL t2_first_addr: got %h want 200", mem_addr); end
    n_checks++; if (core_busy !== 1'b0 || dma_busy !== 1'b1) begin n_fail++; $display("FAIL t2_busy_a: got c%b d%b want c0 d1", core_busy, dma_busy); end
    n_checks++; if (dma_rdata !== 32'h0 || core_rdata !== 32'h12345678) begin n_fail++; $display("FAIL t2_rdata_a: got c%h d%h want c12345678 d0", core_rdata, dma_rdata); end
    core_req = 0;
    wait_done(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t2_dma_timeout: got no completion want completion"); end
    n_checks++; if (arb_owner !== 1'b1) begin n_fail++; $display("FAIL t2_second_owner: got %b want 1", arb_owner); end
    n_checks++; if (mem_addr !== 32'h300) begin n_fail++; $display("FAIL t2_second_addr: got %h want 300", mem_addr); end
    n_checks++; if (dma_busy !== 1'b0) begin n_fail++; $display("FAIL t2_dma_busy: got %b want 0", dma_busy); end
    n_checks++; if (dma_rdata !== 32'h12345678 || core_rdata !== 32'h0) begin n_fail++; $display("FAIL t2_rdata_b: got c%h d%h want c0 d12345678", core_rdata, dma_rdata); end
    dma_req = 0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic exp_own [0:9];
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    wait_cyc = 4'd0;
    core_req = 1; dma_req = 1;
    for (int k = 0; k < 10; k++) begin
      wait_done(10, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL t3_timeout_%0d: got no completion want completion", k); end
      n_checks++; if (arb_owner !== exp_own[k]) begin n_fail++; $display("FAIL t3_grant_%0d: got owner %b want %b", k, arb_owner, exp_own[k]); end
    end
    core_req = 0; dma_req = 0;
    step();
    step();
  endtask

  task automatic test_fault();
    bit ok;
    int fault_cycles;
    int core_bad;
    bit busy_seen;
    ok = 0; fault_cycles = 0; core_bad = 0; busy_seen = 0;
    wait_cyc = 4'd2; f_addr = 1;
    dma_req = 1; dma_write = 1; dma_size = 2'b10; dma_addr = 32'h3; dma_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dma_fault !== 3'b000) fault_cycles++;
      if (core_fault !== 3'b000) core_bad++;
      if (mem_enable && mem_busy && dma_busy) busy_seen = 1;
      if (mem_enable && !mem_busy) begin
        ok = 1;
        n_checks++; if (dma_fault !== 3'b010) begin n_fail++; $display("FAIL t4_fault: got %b want 010", dma_fault); end
        n_checks++; if (arb_owner !== 1'b1) begin n_fail++; $display("FAIL t4_owner: got %b want 1", arb_owner); end
        n_checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h3) begin n_fail++; $display("FAIL t4_req: got w%b a%h want w1 a3", mem_write, mem_addr); end
        n_checks++; if (mem_wdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL t4_wdata: got %h want cafef00d", mem_wdata); end
        break;
      end
    end
    dma_req = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (dma_fault !== 3'b000) fault_cycles++;
      if (core_fault !== 3'b000) core_bad++;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t4_timeout: got no completion want completion"); end
    n_checks++; if (fault_cycles != 1) begin n_fail++; $display("FAIL t4_fault_cycles: got %0d want 1", fault_cycles); end
    n_checks++; if (core_bad != 0) begin n_fail++; $display("FAIL t4_core_fault: got %0d cycles want 0", core_bad); end
    n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL t4_busy_wait: got %b want 1", busy_seen); end
    f_addr = 0; wait_cyc = 4'd0;
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    wait_cyc = 4'd5;
    core_req = 1; core_addr = 32'h400; core_write = 0; dma_req = 1;
    step();
    n_checks++; if (mem_enable !== 1'b1 || mem_busy !== 1'b1) begin n_fail++; $display("FAIL t5_active: got en%b busy%b want en1 busy1", mem_enable, mem_busy); end
    reset_n = 0;
    #1;
    n_checks++; if (mem_enable !== 1'b0) begin n_fail++; $display("FAIL t5_enable: got %b want 0", mem_enable); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL t5_addr: got %h want 0", mem_addr); end
    n_checks++; if (core_busy !== 1'b1 || dma_busy !== 1'b1) begin n_fail++; $display("FAIL t5_busy: got c%b d%b want c1 d1", core_busy, dma_busy); end
    n_checks++; if (arb_owner !== 1'b0) begin n_fail++; $display("FAIL t5_owner: got %b want 0", arb_owner); end
    dma_req = 0;
    #1;
    n_checks++; if (dma_busy !== 1'b0) begin n_fail++; $display("FAIL t5_dma_busy_low: got %b want 0", dma_busy); end
    step();
    reset_n = 1; wait_cyc = 4'd0; mem_out = 32'hA5A55A5A;
    wait_done(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t5_timeout: got no completion want completion"); end
    n_checks++; if (arb_owner !== 1'b0 || mem_addr !== 32'h400) begin n_fail++; $display("FAIL t5_regrant: got o%b a%h want o0 a400", arb_owner, mem_addr); end
    n_checks++; if (core_rdata !== 32'hA5A55A5A || core_busy !== 1'b0) begin n_fail++; $display("FAIL t5_rdata: got %h busy%b want a5a55a5a busy0", core_rdata, core_busy); end
    core_req = 0;
    step();
    step();
  endtask

  task automatic test_lock();
    bit ok;
    logic exp_own [0:4];
`ifdef MEM_ARB_LOCK_EN
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_own = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    wait_cyc = 4'd0;
    dma_req = 1; dma_lock = 1; dma_addr = 32'h500; dma_write = 0; core_req = 0;
    for (int k = 0; k < 5; k++) begin
      wait_done(12, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL t6_timeout_%0d: got no completion want completion", k); end
      n_checks++; if (arb_owner !== exp_own[k]) begin n_fail++; $display("FAIL t6_grant_%0d: got owner %b want %b", k, arb_owner, exp_own[k]); end
      if (k == 0) core_req = 1;
      if (k == 2) begin
        // Move past this completion so it still samples dma_lock=1.
        step();
        dma_lock = 0;
      end
    end
    core_req = 0; dma_req = 0; dma_lock = 0;
    step();
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_core_only();
    test_simultaneous();
    test_back_to_back();
    test_fault();
    test_reset_mid_op();
    test_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
